// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direction predictor for the fetch stage of the 5-stage pipeline. A table of
// 2-bit saturating counters (PHT) is indexed from the fetch PC, optionally
// XORed with global history (gshare) or with a per-PC local history read from
// a small branch history table (BHT). Training happens only from the M-stage
// branch outcome bus, so all history is architectural (non-speculative).
//
// After reset a sequential sweep initialises every PHT entry to weakly
// not-taken and every BHT entry to zero. While the sweep runs, predictions are
// forced not-taken and M-stage updates are discarded.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst              : asynchronous reset, active low
//   pcF              : fetch PC
//   predict_takeF    : predicted direction for pcF
//   pc_hashingF      : BHT index for pcF (carried to M by the datapath)
//   PHT_indexF       : PHT index for pcF (carried to M by the datapath)
//   branchM          : M-stage instruction is a conditional branch
//   actually_takenM  : resolved branch direction
//   predict_resultM  : 1 when the fetch-time prediction was correct
//   pc_hashingM      : BHT index captured at fetch
//   PHT_indexM       : PHT index captured at fetch
//   init_busy        : initialisation sweep in progress
//   perf_branches    : saturating count of resolved branches
//   perf_mispredicts : saturating count of mispredicted branches
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int PC_HASH_BITS   = 3,
    parameter int PHT_INDEX_BITS = 7,
    parameter int HIST_BITS      = 7,
    parameter int MODE           = 1,
    parameter int PERF_W         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    output logic                      predict_takeF,
    output logic [PC_HASH_BITS-1:0]   pc_hashingF,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
    input  logic                      branchM,
    input  logic                      actually_takenM,
    input  logic                      predict_resultM,
    input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
    input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
    output logic                      init_busy,
    output logic [PERF_W-1:0]         perf_branches,
    output logic [PERF_W-1:0]         perf_mispredicts
);

    localparam int unsigned PHT_DEPTH = 1 << PHT_INDEX_BITS;
    localparam int unsigned BHT_DEPTH = 1 << PC_HASH_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -------------------------------------------------------------------------
    // Parameter legality
    // -------------------------------------------------------------------------
    if (MODE != 0 && MODE != 1 && MODE != 2) begin : g_bad_mode
        $error("branch_predictor: MODE must be 0, 1 or 2");
    end

    if (HIST_BITS < 1 || HIST_BITS > PHT_INDEX_BITS) begin : g_bad_hist
        $error("branch_predictor: HIST_BITS must be in 1..PHT_INDEX_BITS");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]                state_q, state_d;
    logic [PHT_INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [HIST_BITS-1:0]      ghr_q, ghr_d;
    logic [PERF_W-1:0]         br_cnt_q, br_cnt_d;
    logic [PERF_W-1:0]         mp_cnt_q, mp_cnt_d;

    logic [1:0]                pht_q [PHT_DEPTH];
    logic [1:0]                pht_d [PHT_DEPTH];
    logic [HIST_BITS-1:0]      bht_q [BHT_DEPTH];
    logic [HIST_BITS-1:0]      bht_d [BHT_DEPTH];

    // Shift a new outcome into a history register. The size cast drops the
    // oldest bit and also covers the single-bit history case without a
    // negative-width slice.
    function automatic logic [HIST_BITS-1:0] shift_in(
        input logic [HIST_BITS-1:0] hist,
        input logic                 taken
    );
        return HIST_BITS'({hist, taken});
    endfunction

    // 2-bit saturating counter step.
    function automatic logic [1:0] sat2(
        input logic [1:0] cnt,
        input logic       up
    );
        if (up) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Fetch-side lookup (purely combinational, reads pre-update table state)
    // -------------------------------------------------------------------------
    logic [PHT_INDEX_BITS-1:0] pc_lo;
    logic [PHT_INDEX_BITS-1:0] hist_sel;
    logic                      unused_pc;

    assign pc_lo       = pcF[PHT_INDEX_BITS+1:2];
    assign pc_hashingF = pcF[PC_HASH_BITS+1:2];
    assign unused_pc   = ^pcF;

    // History is zero-extended to the PHT index width before the XOR.
    if (MODE == 0) begin : g_bimodal
        assign hist_sel = '0;
    end else if (MODE == 1) begin : g_gshare
        assign hist_sel = PHT_INDEX_BITS'(ghr_q);
    end else begin : g_local
        assign hist_sel = PHT_INDEX_BITS'(bht_q[pc_hashingF]);
    end

    assign PHT_indexF    = pc_lo ^ hist_sel;
    assign init_busy     = (state_q == ST_INIT);
    assign predict_takeF = pht_q[PHT_indexF][1] & ~init_busy;

    assign perf_branches    = br_cnt_q;
    assign perf_mispredicts = mp_cnt_q;

    // -------------------------------------------------------------------------
    // Initialisation sweep and M-stage training
    // -------------------------------------------------------------------------
    logic [PC_HASH_BITS-1:0] bht_clr_idx;
    logic                    bht_clr_en;

    // The sweep pointer spans the PHT; only its low values address the BHT.
    assign bht_clr_idx = PC_HASH_BITS'(ptr_q);
    assign bht_clr_en  = (32'(ptr_q) < BHT_DEPTH);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ghr_d    = ghr_q;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        pht_d    = pht_q;
        bht_d    = bht_q;

        if (state_q == ST_INIT) begin
            // Updates arriving during the sweep are discarded entirely.
            pht_d[ptr_q] = 2'b01;
            if (bht_clr_en) begin
                bht_d[bht_clr_idx] = '0;
            end
            ptr_d = ptr_q + PHT_INDEX_BITS'(1);
            if (ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end else if (branchM) begin
            pht_d[PHT_indexM]  = sat2(pht_q[PHT_indexM], actually_takenM);
            ghr_d              = shift_in(ghr_q, actually_takenM);
            bht_d[pc_hashingM] = shift_in(bht_q[pc_hashingM], actually_takenM);
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + PERF_W'(1);
            end
            if (!predict_resultM && (mp_cnt_q != '1)) begin
                mp_cnt_d = mp_cnt_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            ghr_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ghr_q    <= ghr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    // Table contents are not reset directly; the sweep initialises them.
    always_ff @(posedge clk) begin
        pht_q <= pht_d;
        bht_q <= bht_d;
    end

endmodule
